// File: rtl/vga_timing_monitor.sv
// Receive-side checker for the VGA sync generator: measures line/frame timing,
// locks after two matching frames, recovers x/y and samples one probe pixel.
module vga_timing_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_OFFSET = 144,
  parameter int V_OFFSET = 35,
  parameter int PIX_LAT  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HS,
  input  logic        VS,
  input  logic [2:0]  Red,
  input  logic [2:0]  Green,
  input  logic [1:0]  Blue,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [10:0] h_total,
  output logic [10:0] h_sync_w,
  output logic [10:0] v_total,
  output logic [10:0] v_sync_w,
  output logic        locked,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        active,
  output logic [7:0]  probe_rgb,
  output logic        probe_valid,
  output logic [7:0]  frame_count,
  output logic [7:0]  err_count
);
  typedef enum logic [1:0] {SEARCH, MEASURE, CONFIRM, LOCKED} state_t;

  state_t      state_q;
  logic        hs_q, vs_q;
  logic [10:0] hc_q, lc_q, len_q, hsw_q, vsw_q;
  logic [10:0] ht_q, hw_q, vt_q, vw_q;
  logic [9:0]  x_q, y_q;
  logic        active_q, pv_q;
  logic [7:0]  prgb_q, fc_q, ec_q;

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic        hc_sat, is_locked, line_bad, frame_bad, probe_hit, h_vis, v_vis;
  logic [10:0] hc_plus, frame_lines, line_len;
  logic [11:0] hc_x, lc_x, px_tgt, py_tgt;

  assign hs_fall = hs_q & ~HS;
  assign hs_rise = ~hs_q & HS;
  assign vs_fall = vs_q & ~VS;
  assign vs_rise = ~vs_q & VS;

  assign hc_sat = (hc_q == 11'h7FF);
  // Cycles since HS fell, including the fall cycle itself: the line length at
  // the next fall and the true low width at the rise.
  assign hc_plus     = hc_sat ? hc_q : hc_q + 11'd1;
  assign frame_lines = lc_q + {10'd0, hs_fall};
  assign line_len    = hs_fall ? hc_plus : len_q;
  assign line_bad    = (hs_fall && hc_plus != ht_q) || (hs_rise && hc_plus != hw_q);
  assign frame_bad   = (frame_lines != vt_q) || (vsw_q != vw_q);
  assign is_locked   = (state_q == LOCKED);

  assign hc_x   = {1'b0, hc_q};
  assign lc_x   = {1'b0, lc_q};
  assign px_tgt = 12'(H_OFFSET) + {2'b00, probe_x} + 12'(PIX_LAT);
  assign py_tgt = 12'(V_OFFSET) + {2'b00, probe_y};
  assign h_vis  = (hc_x >= 12'(H_OFFSET)) && (hc_x < 12'(H_OFFSET + H_ACTIVE));
  assign v_vis  = (lc_x >= 12'(V_OFFSET)) && (lc_x < 12'(V_OFFSET + V_ACTIVE));
  assign probe_hit = is_locked && (hc_x == px_tgt) && (lc_x == py_tgt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= SEARCH;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      hc_q     <= '0;
      lc_q     <= '0;
      len_q    <= '0;
      hsw_q    <= '0;
      vsw_q    <= '0;
      ht_q     <= '0;
      hw_q     <= '0;
      vt_q     <= '0;
      vw_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      pv_q     <= 1'b0;
      prgb_q   <= '0;
      fc_q     <= '0;
      ec_q     <= '0;
    end else begin
      hs_q <= HS;
      vs_q <= VS;
      hc_q <= hs_fall ? 11'd0 : hc_plus;
      lc_q <= vs_fall ? 11'd0 : frame_lines;
      if (hs_fall) len_q <= hc_plus;
      if (hs_rise) hsw_q <= hc_plus;
      if (vs_rise) vsw_q <= frame_lines;

      x_q      <= 10'(hc_q - 11'(H_OFFSET));
      y_q      <= 10'(lc_q - 11'(V_OFFSET));
      active_q <= is_locked && h_vis && v_vis;
      pv_q     <= probe_hit;
      if (probe_hit) prgb_q <= {Red, Green, Blue};
      if (is_locked && vs_fall) fc_q <= fc_q + 8'd1;

      case (state_q)
        SEARCH:  if (vs_fall) state_q <= MEASURE;
        MEASURE: if (vs_fall) begin
          if (frame_lines < 11'd2) begin
            state_q <= SEARCH;
          end else begin
            ht_q    <= line_len;
            hw_q    <= hsw_q;
            vt_q    <= frame_lines;
            vw_q    <= vsw_q;
            state_q <= CONFIRM;
          end
        end
        CONFIRM: begin
          if (line_bad)     state_q <= SEARCH;
          else if (vs_fall) state_q <= frame_bad ? SEARCH : LOCKED;
        end
        default: if (line_bad || hc_sat || (vs_fall && frame_bad)) begin
          state_q <= SEARCH;
          if (ec_q != 8'hFF) ec_q <= ec_q + 8'd1;
        end
      endcase
    end
  end

  assign h_total     = ht_q;
  assign h_sync_w    = hw_q;
  assign v_total     = vt_q;
  assign v_sync_w    = vw_q;
  assign locked      = is_locked;
  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign probe_rgb   = prgb_q;
  assign probe_valid = pv_q;
  assign frame_count = fc_q;
  assign err_count   = ec_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor: a small-geometry sync source with fault
// injection, an event-level reference model checked every cycle, and literal pins.
module tb_vga_timing_monitor;
  localparam int HT = 40, HSW = 6, HO = 10, HA = 24;
  localparam int VT = 12, VSW = 2, VO = 4, VA = 6;
  localparam int PL = 1;

  logic        CLK = 1'b0;
  logic        RST, HS, VS;
  logic [2:0]  Red, Green;
  logic [1:0]  Blue;
  logic [9:0]  probe_x, probe_y;
  logic [10:0] h_total, h_sync_w, v_total, v_sync_w;
  logic        locked, active, probe_valid;
  logic [9:0]  x, y;
  logic [7:0]  probe_rgb, frame_count, err_count;

  always #5 CLK = ~CLK;

  vga_timing_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_OFFSET(HO), .V_OFFSET(VO),
                       .PIX_LAT(PL)) dut (
    .CLK(CLK), .RST(RST), .HS(HS), .VS(VS), .Red(Red), .Green(Green), .Blue(Blue),
    .probe_x(probe_x), .probe_y(probe_y), .h_total(h_total), .h_sync_w(h_sync_w),
    .v_total(v_total), .v_sync_w(v_sync_w), .locked(locked), .x(x), .y(y),
    .active(active), .probe_rgb(probe_rgb), .probe_valid(probe_valid),
    .frame_count(frame_count), .err_count(err_count));

  int n_tests = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- sync source ----------------
  int sl, sh, pl_, ph_, cur_ht, cur_vt, src_frames = 0, pulses = 0;
  bit long_line_req = 0, long_frame_req = 0, hs_hold = 0;

  function automatic int pix(int px, int py);
    return (px * 7 + py * 13 + 'hE3) & 255;
  endfunction

  // Syncs reflect the next position; the colour bus is one cycle behind.
  task automatic step();
    int nh, nl2, bus;
    @(negedge CLK);
    pulses += int'(probe_valid);
    nh = sh + 1; nl2 = sl;
    if (nh >= cur_ht) begin
      nh = 0; nl2 = sl + 1;
      if (nl2 >= cur_vt) nl2 = 0;
    end
    HS = hs_hold ? 1'b0 : !(nh < HSW);
    VS = hs_hold ? 1'b1 : !(nl2 < VSW);
    bus = (ph_ >= HO && ph_ < HO + HA && pl_ >= VO && pl_ < VO + VA) ? pix(ph_ - HO, pl_ - VO) : 0;
    {Red, Green, Blue} = 8'(bus);
    pl_ = sl; ph_ = sh;
    if (nh == 0) begin
      cur_ht = long_line_req ? HT + 1 : HT;
      long_line_req = 0;
      if (nl2 == 0) begin
        cur_vt = long_frame_req ? VT + 1 : VT;
        long_frame_req = 0;
        src_frames++;
      end
    end
    sl = nl2; sh = nh;
  endtask

  task automatic wait_vf(int n);
    int tgt = src_frames + n;
    int guard = 0;
    while (src_frames < tgt && guard < 3 * HT * VT * n + 100) begin
      step();
      guard++;
    end
    if (src_frames < tgt) chk("vf_timeout", src_frames, tgt);
    step();
    step();
  endtask

  // ---------------- reference model (event level) ----------------
  int m_t = 0, m_thf = 0, m_nl = 0, m_len = 0, m_hwl = 0, m_vwl = 0;
  int m_ht = 0, m_hw = 0, m_vt = 0, m_vw = 0, m_stg = 0, m_fc = 0, m_ec = 0;
  int m_x = 0, m_y = 0, m_rgb = 0;
  bit m_act = 0, m_pv = 0, m_phs = 1, m_pvs = 1;

  task automatic model_step();
    int hc, span, fl;
    bit hf, hr, vf, vr, lk, bad;
    m_t++;
    if (RST) begin
      m_thf = m_t; m_nl = 0; m_len = 0; m_hwl = 0; m_vwl = 0;
      m_ht = 0; m_hw = 0; m_vt = 0; m_vw = 0; m_stg = 0; m_fc = 0; m_ec = 0;
      m_x = 0; m_y = 0; m_act = 0; m_pv = 0; m_rgb = 0; m_phs = 1; m_pvs = 1;
      return;
    end
    span = m_t - m_thf;           // cycles since the last HS fall, fall cycle included
    if (span > 2047) span = 2047;
    hc = m_t - m_thf - 1;
    if (hc > 2047) hc = 2047;
    hf = m_phs && !HS; hr = !m_phs && HS;
    vf = m_pvs && !VS; vr = !m_pvs && VS;
    fl = m_nl + int'(hf);
    lk = (m_stg == 3);
    m_x   = (hc - HO) & 1023;
    m_y   = (m_nl - VO) & 1023;
    m_act = lk && hc >= HO && hc < HO + HA && m_nl >= VO && m_nl < VO + VA;
    m_pv  = lk && hc == HO + int'(probe_x) + PL && m_nl == VO + int'(probe_y);
    if (m_pv) m_rgb = int'({Red, Green, Blue});
    if (lk && vf) m_fc = (m_fc + 1) % 256;
    bad = (hf && span != m_ht) || (hr && span != m_hw);
    case (m_stg)
      0: if (vf) m_stg = 1;
      1: if (vf) begin
        if (fl < 2) m_stg = 0;
        else begin
          m_ht = hf ? span : m_len; m_hw = m_hwl; m_vt = fl; m_vw = m_vwl; m_stg = 2;
        end
      end
      2: if (bad) m_stg = 0;
         else if (vf) m_stg = (fl == m_vt && m_vwl == m_vw) ? 3 : 0;
      default: if (bad || hc == 2047 || (vf && (fl != m_vt || m_vwl != m_vw))) begin
        m_stg = 0;
        if (m_ec < 255) m_ec++;
      end
    endcase
    if (hf) begin m_len = span; m_thf = m_t; end
    if (hr) m_hwl = span;
    if (vr) m_vwl = fl;
    m_nl = vf ? 0 : fl;
    m_phs = HS; m_pvs = VS;
  endtask

  initial begin
    logic [90:0] act_v, exp_v;
    forever begin
      @(posedge CLK);
      model_step();
      #1;
      if (chk_en) begin
        act_v = {h_total, h_sync_w, v_total, v_sync_w, locked, x, y, active,
                 probe_rgb, probe_valid, frame_count, err_count};
        exp_v = {11'(m_ht), 11'(m_hw), 11'(m_vt), 11'(m_vw), (m_stg == 3), 10'(m_x), 10'(m_y),
                 m_act, 8'(m_rgb), m_pv, 8'(m_fc), 8'(m_ec)};
        n_tests++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL outputs t=%0t got %h expected %h", $time, act_v, exp_v);
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int guard;
    RST = 1; HS = 1; VS = 1; {Red, Green, Blue} = 8'h00;
    probe_x = 10'd0; probe_y = 10'd0;
    sl = VT - 1; sh = HT - 8; pl_ = sl; ph_ = sh - 1; cur_ht = HT; cur_vt = VT;
    step();
    chk_en = 1;
    step(); step();
    chk("rst_locked", int'(locked), 0);
    chk("rst_h_total", int'(h_total), 0);
    RST = 0;

    wait_vf(2);
    chk("no_lock_at_2nd_vf", int'(locked), 0);
    wait_vf(1);
    chk("lock_at_3rd_vf", int'(locked), 1);
    chk("h_total", int'(h_total), 40);
    chk("h_sync_w", int'(h_sync_w), 6);
    chk("v_total", int'(v_total), 12);
    chk("v_sync_w", int'(v_sync_w), 2);

    pulses = 0;
    wait_vf(1);
    chk("probe00_pulses", pulses, 1);
    chk("probe00_rgb", int'(probe_rgb), 'hE3);

    probe_x = 10'd23; probe_y = 10'd5;
    pulses = 0;
    wait_vf(1);
    chk("probe_last_pulses", pulses, 1);
    chk("probe_last_rgb", int'(probe_rgb), 'hC5);
    chk("frame_count", int'(frame_count), 2);

    long_line_req = 1;
    wait_vf(1);
    chk("long_line_unlock", int'(locked), 0);
    chk("long_line_err", int'(err_count), 1);
    wait_vf(2);
    chk("long_line_relock", int'(locked), 1);

    repeat (100) step();
    RST = 1;
    step();
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_err", int'(err_count), 0);
    chk("midrst_fc", int'(frame_count), 0);
    chk("midrst_v_total", int'(v_total), 0);
    RST = 0;

    wait_vf(1);
    long_frame_req = 1;
    wait_vf(2);
    chk("long_frame_nolock", int'(locked), 0);
    chk("long_frame_err", int'(err_count), 0);
    chk("long_frame_vtotal", int'(v_total), 12);
    wait_vf(3);
    chk("long_frame_relock", int'(locked), 1);

    guard = 0;
    while (!(sl == 6 && sh == 2) && guard < 2000) begin step(); guard++; end
    chk("hold_start_found", int'(sl == 6 && sh == 2), 1);
    hs_hold = 1;
    repeat (3000) step();
    hs_hold = 0;
    chk("hold_unlock", int'(locked), 0);
    chk("hold_err_once", int'(err_count), 1);
    wait_vf(6);
    chk("hold_relock", int'(locked), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
